sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Single-clock, parametrised FIFO. It is the single-domain successor of the team's asynchronous FIFO, for paths where producer and consumer share one clock. It adds programmable almost-full/almost-empty thresholds, an occupancy count and a free-slot count, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. No pointer synchronisers are needed; all flags are exact and have no latency skew.

Parameters:
D_SIZE, 8, data width in bits (>=1).
F_DEPTH, 16, number of entries; power of two, >=4.
P_SIZE, 5, pointer/count width; must equal log2(F_DEPTH)+1.
AF_THRESH, 12, o_almost_full asserts when occupancy >= AF_THRESH (1..F_DEPTH).
AE_THRESH, 4, o_almost_empty asserts when occupancy <= AE_THRESH (0..F_DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
i_clk  input  1  operating clock, all logic on rising edge.
i_rst  input  1  synchronous active-high reset.
i_w_inc  input  1  write request.
i_w_data  input  D_SIZE  write data.
i_r_inc  input  1  read request (FWFT: pop/acknowledge head).
i_clr_err  input  1  clears sticky error flags.
o_r_data  output  D_SIZE  read data.
o_r_valid  output  1  standard mode: read data valid this cycle; FWFT: equals ~o_empty.
o_full  output  1  occupancy == F_DEPTH.
o_empty  output  1  occupancy == 0.
o_almost_full  output  1  occupancy >= AF_THRESH.
o_almost_empty  output  1  occupancy <= AE_THRESH.
o_count  output  P_SIZE  current occupancy, 0..F_DEPTH.
o_free_count  output  P_SIZE  F_DEPTH - o_count.
o_overflow  output  1  sticky: a write was attempted while full.
o_underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - Write/read pointers and count are 0. o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0.
  - o_free_count=F_DEPTH; o_overflow=0, o_underflow=0; o_r_valid=0; o_r_data=0 in standard mode.
  - Memory contents are not reset.
  - Reset overrides every other input in the same cycle, including i_clr_err. Asserting reset mid-stream discards all stored data.
- Accept rules:
  - wr_acc = i_w_inc & ~o_full. rd_acc = i_r_inc & ~o_empty.
  - Flags are evaluated on the current registered state. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write occurs in the same cycle.
- Pointers are P_SIZE bits. The address is the low P_SIZE-1 bits; the MSB is the wrap bit. Pointers wrap naturally modulo 2*F_DEPTH.
- Count update: count <= count + wr_acc - rd_acc. A simultaneous accepted read and write leaves count unchanged. All flag outputs and both counts derive combinationally from the registered count, so they are valid the cycle after the edge that changed it.
- Write: on wr_acc, mem[wr_addr] <= i_w_data and wr_ptr increments.
- Standard read (FWFT=0):
  - On rd_acc, o_r_data <= mem[rd_addr] and rd_ptr increments. o_r_valid is 1 for exactly the following cycle.
  - o_r_data holds its last value otherwise. Read latency is 1 cycle.
- FWFT read (FWFT=1):
  - o_r_data = mem[rd_addr] combinationally whenever o_empty=0. It is don't-care while empty.
  - A word written into an empty FIFO is visible one cycle after the write edge.
  - rd_acc advances the head; the next word appears the following cycle.
- Error flags:
  - o_overflow is set when i_w_inc & o_full. o_underflow is set when i_r_inc & o_empty.
  - Both are cleared by i_clr_err. If set and clear occur in the same cycle, set wins.
  - Rejected operations change no pointers or memory.
- Threshold boundaries: with AF_THRESH=F_DEPTH, o_almost_full equals o_full. With AE_THRESH=0, o_almost_empty equals o_empty.

Test Plan:
1. Defaults, FWFT=0. Reset, then write 0x01..0x10 on consecutive cycles -> o_count steps 1..16; o_almost_full rises when count reaches 12; o_full=1 at 16; o_free_count=0; o_almost_empty drops when count reaches 5.
2. While full, assert i_w_inc=1 with data 0xAA -> o_overflow=1, count stays 16, 0xAA is never read. Then i_clr_err=1 -> o_overflow=0 next cycle.
3. Drain a full FIFO with i_r_inc held for 16 cycles -> o_r_data sequence 0x01..0x10, each with o_r_valid=1 one cycle after its read. A 17th read sets o_underflow=1 and o_r_valid stays 0.
4. Hold count at 8 with i_w_inc=i_r_inc=1 for 32 cycles (pointers wrap twice) -> count stays 8 and data order is preserved. Also: full + simultaneous read/write -> read accepted, write rejected, count becomes 15, o_overflow=1.
5. FWFT=1. Write 0x5A into an empty FIFO -> o_r_data=0x5A and o_empty=0 the next cycle, before any i_r_inc. One pop -> o_empty=1 next cycle.
6. Assert i_rst with count=9 and o_overflow=1, together with i_clr_err=1 and i_w_inc=1 -> next cycle count=0, o_empty=1, o_overflow=0, no write performed.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle for sync_fifo.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface sync_fifo_if #(
    parameter int D_SIZE = 8,
    parameter int P_SIZE = 5
);
    logic              i_w_inc;
    logic [D_SIZE-1:0] i_w_data;
    logic              i_r_inc;
    logic              i_clr_err;
    logic [D_SIZE-1:0] o_r_data;
    logic              o_r_valid;
    logic              o_full;
    logic              o_empty;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic [P_SIZE-1:0] o_count;
    logic [P_SIZE-1:0] o_free_count;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output i_w_inc, i_w_data, i_r_inc, i_clr_err,
        input  o_r_data, o_r_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_free_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_w_inc, i_w_data, i_r_inc, i_clr_err,
        output o_r_data, o_r_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_free_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with exact occupancy flags, programmable thresholds,
// sticky overflow/underflow and selectable registered or FWFT read.
module sync_fifo #(
    parameter int D_SIZE    = 8,
    parameter int F_DEPTH   = 16,
    parameter int P_SIZE    = 5,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = 0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    sync_fifo_if.slave bus
);
    localparam int                A_SIZE  = P_SIZE - 1;
    localparam logic [P_SIZE-1:0] DEPTH_C = P_SIZE'(F_DEPTH);
    localparam logic [P_SIZE-1:0] AF_C    = P_SIZE'(AF_THRESH);
    localparam logic [P_SIZE-1:0] AE_C    = P_SIZE'(AE_THRESH);
    localparam logic [P_SIZE-1:0] ONE_C   = P_SIZE'(1);

    logic [D_SIZE-1:0] mem_q [F_DEPTH];

    logic [P_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [P_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [P_SIZE-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic [D_SIZE-1:0] head_data;

    // Accept decisions look only at registered state, so a full FIFO refuses
    // a write even when a read drains a slot in the same cycle.
    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        wr_acc      = bus.i_w_inc & ~full;
        rd_acc      = bus.i_r_inc & ~empty;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
        if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Clear first so a coincident error event wins.
        if (bus.i_clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.i_w_inc & full)  overflow_d  = 1'b1;
        if (bus.i_r_inc & empty) underflow_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; reset only blocks the write that would
    // otherwise land in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_acc) begin
            mem_q[wr_ptr_q[A_SIZE-1:0]] <= bus.i_w_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q[A_SIZE-1:0]];

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.o_r_data  = head_data;
            assign bus.o_r_valid = ~empty;
        end else begin : g_std
            logic [D_SIZE-1:0] r_data_q, r_data_d;
            logic              r_valid_q, r_valid_d;

            always_comb begin
                r_data_d  = r_data_q;
                r_valid_d = rd_acc;
                if (rd_acc) r_data_d = head_data;
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else begin
                    r_data_q  <= r_data_d;
                    r_valid_q <= r_valid_d;
                end
            end

            assign bus.o_r_data  = r_data_q;
            assign bus.o_r_valid = r_valid_q;
        end
    endgenerate

    assign bus.o_full         = full;
    assign bus.o_empty        = empty;
    assign bus.o_almost_full  = (count_q >= AF_C);
    assign bus.o_almost_empty = (count_q <= AE_C);
    assign bus.o_count        = count_q;
    assign bus.o_free_count   = DEPTH_C - count_q;
    assign bus.o_overflow     = overflow_q;
    assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read instance with default
// thresholds and an FWFT instance with thresholds at their boundary values.
module tb_sync_fifo;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    sync_fifo_if #(.D_SIZE(8), .P_SIZE(5)) sif ();
    sync_fifo_if #(.D_SIZE(8), .P_SIZE(5)) fif ();

    sync_fifo #(.D_SIZE(8), .F_DEPTH(16), .P_SIZE(5), .AF_THRESH(12),
                .AE_THRESH(4), .FWFT(0))
        u_std (.i_clk(clk), .i_rst(rst), .bus(sif));

    sync_fifo #(.D_SIZE(8), .F_DEPTH(16), .P_SIZE(5), .AF_THRESH(16),
                .AE_THRESH(0), .FWFT(1))
        u_fwft (.i_clk(clk), .i_rst(rst), .bus(fif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sif.i_w_inc = 0; sif.i_w_data = '0; sif.i_r_inc = 0; sif.i_clr_err = 0;
        fif.i_w_inc = 0; fif.i_w_data = '0; fif.i_r_inc = 0; fif.i_clr_err = 0;
    endtask

    task automatic clear_errors();
        sif.i_clr_err = 1; fif.i_clr_err = 1;
        tick();
        sif.i_clr_err = 0; fif.i_clr_err = 0;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        n_vec++; if (sif.o_count !== 5'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", sif.o_count); end
        n_vec++; if (sif.o_empty !== 1'b1 || sif.o_full !== 1'b0) begin n_err++; $display("FAIL rst_empty_full: got %b/%b expected 1/0", sif.o_empty, sif.o_full); end
        n_vec++; if (sif.o_almost_empty !== 1'b1 || sif.o_almost_full !== 1'b0) begin n_err++; $display("FAIL rst_almost: got ae=%b af=%b expected 1/0", sif.o_almost_empty, sif.o_almost_full); end
        n_vec++; if (sif.o_free_count !== 5'd16) begin n_err++; $display("FAIL rst_free: got %0d expected 16", sif.o_free_count); end
        n_vec++; if (sif.o_overflow !== 1'b0 || sif.o_underflow !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b/%b expected 0/0", sif.o_overflow, sif.o_underflow); end
        n_vec++; if (sif.o_r_valid !== 1'b0 || sif.o_r_data !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got v=%b d=%h expected 0/00", sif.o_r_valid, sif.o_r_data); end
        n_vec++; if (fif.o_empty !== 1'b1 || fif.o_r_valid !== 1'b0) begin n_err++; $display("FAIL rst_fwft: got empty=%b valid=%b expected 1/0", fif.o_empty, fif.o_r_valid); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            sif.i_w_inc = 1; sif.i_w_data = 8'(i);
            tick();
            n_vec++; if (sif.o_count !== 5'(i)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, sif.o_count, i); end
            n_vec++; if (sif.o_free_count !== 5'(16 - i)) begin n_err++; $display("FAIL fill_free[%0d]: got %0d expected %0d", i, sif.o_free_count, 16 - i); end
            n_vec++; if (sif.o_almost_full !== (i >= 12)) begin n_err++; $display("FAIL fill_af[%0d]: got %b expected %b", i, sif.o_almost_full, i >= 12); end
            n_vec++; if (sif.o_almost_empty !== (i <= 4)) begin n_err++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, sif.o_almost_empty, i <= 4); end
            n_vec++; if (sif.o_full !== (i == 16)) begin n_err++; $display("FAIL fill_full[%0d]: got %b expected %b", i, sif.o_full, i == 16); end
        end
        sif.i_w_inc = 0;
    endtask

    task automatic test_overflow();
        sif.i_w_inc = 1; sif.i_w_data = 8'hAA;
        tick();
        sif.i_w_inc = 0;
        n_vec++; if (sif.o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", sif.o_overflow); end
        n_vec++; if (sif.o_count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d expected 16", sif.o_count); end
        sif.i_clr_err = 1;
        tick();
        sif.i_clr_err = 0;
        n_vec++; if (sif.o_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", sif.o_overflow); end
        sif.i_w_inc = 1; sif.i_clr_err = 1; sif.i_w_data = 8'hAB;
        tick();
        sif.i_w_inc = 0; sif.i_clr_err = 0;
        n_vec++; if (sif.o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b expected 1", sif.o_overflow); end
        clear_errors();
    endtask

    task automatic test_drain();
        sif.i_r_inc = 1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_vec++; if (sif.o_r_data !== 8'(k) || sif.o_r_valid !== 1'b1) begin n_err++; $display("FAIL drain_data[%0d]: got d=%h v=%b expected %h/1", k, sif.o_r_data, sif.o_r_valid, 8'(k)); end
            n_vec++; if (sif.o_count !== 5'(16 - k)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, sif.o_count, 16 - k); end
        end
        tick();
        sif.i_r_inc = 0;
        n_vec++; if (sif.o_underflow !== 1'b1) begin n_err++; $display("FAIL unf_set: got %b expected 1", sif.o_underflow); end
        n_vec++; if (sif.o_r_valid !== 1'b0 || sif.o_r_data !== 8'h10) begin n_err++; $display("FAIL unf_rdata: got v=%b d=%h expected 0/10", sif.o_r_valid, sif.o_r_data); end
        n_vec++; if (sif.o_empty !== 1'b1 || sif.o_count !== 5'd0) begin n_err++; $display("FAIL unf_empty: got e=%b c=%0d expected 1/0", sif.o_empty, sif.o_count); end
        clear_errors();
        n_vec++; if (sif.o_underflow !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b expected 0", sif.o_underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            sif.i_w_inc = 1; sif.i_w_data = 8'(8'h20 + i);
            tick();
        end
        sif.i_r_inc = 1;
        for (int j = 0; j < 32; j++) begin
            sif.i_w_data = 8'(8'h28 + j);
            tick();
            n_vec++; if (sif.o_r_data !== 8'(8'h20 + j) || sif.o_r_valid !== 1'b1) begin n_err++; $display("FAIL b2b_data[%0d]: got d=%h v=%b expected %h/1", j, sif.o_r_data, sif.o_r_valid, 8'(8'h20 + j)); end
            n_vec++; if (sif.o_count !== 5'd8) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d expected 8", j, sif.o_count); end
        end
        sif.i_w_inc = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            n_vec++; if (sif.o_r_data !== 8'(8'h40 + j)) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h expected %h", j, sif.o_r_data, 8'(8'h40 + j)); end
        end
        sif.i_r_inc = 0;
        for (int i = 0; i < 16; i++) begin
            sif.i_w_inc = 1; sif.i_w_data = 8'(8'h60 + i);
            tick();
        end
        sif.i_w_data = 8'hBB; sif.i_r_inc = 1;
        tick();
        sif.i_w_inc = 0; sif.i_r_inc = 0;
        n_vec++; if (sif.o_count !== 5'd15) begin n_err++; $display("FAIL fullrw_count: got %0d expected 15", sif.o_count); end
        n_vec++; if (sif.o_overflow !== 1'b1) begin n_err++; $display("FAIL fullrw_ovf: got %b expected 1", sif.o_overflow); end
        n_vec++; if (sif.o_r_data !== 8'h60) begin n_err++; $display("FAIL fullrw_rdata: got %h expected 60", sif.o_r_data); end
        sif.i_r_inc = 1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_vec++; if (sif.o_r_data !== 8'(8'h60 + k)) begin n_err++; $display("FAIL fullrw_drain[%0d]: got %h expected %h", k, sif.o_r_data, 8'(8'h60 + k)); end
        end
        sif.i_r_inc = 0;
        n_vec++; if (sif.o_empty !== 1'b1) begin n_err++; $display("FAIL fullrw_empty: got %b expected 1", sif.o_empty); end
        clear_errors();
    endtask

    task automatic test_fwft();
        fif.i_w_inc = 1; fif.i_w_data = 8'h5A;
        tick();
        fif.i_w_inc = 0;
        n_vec++; if (fif.o_r_data !== 8'h5A || fif.o_empty !== 1'b0 || fif.o_r_valid !== 1'b1) begin n_err++; $display("FAIL fwft_show: got d=%h e=%b v=%b expected 5a/0/1", fif.o_r_data, fif.o_empty, fif.o_r_valid); end
        n_vec++; if (fif.o_almost_empty !== 1'b0) begin n_err++; $display("FAIL fwft_ae0: got %b expected 0", fif.o_almost_empty); end
        tick();
        n_vec++; if (fif.o_r_data !== 8'h5A || fif.o_count !== 5'd1) begin n_err++; $display("FAIL fwft_hold: got d=%h c=%0d expected 5a/1", fif.o_r_data, fif.o_count); end
        fif.i_r_inc = 1;
        tick();
        fif.i_r_inc = 0;
        n_vec++; if (fif.o_empty !== 1'b1 || fif.o_r_valid !== 1'b0 || fif.o_almost_empty !== 1'b1) begin n_err++; $display("FAIL fwft_pop: got e=%b v=%b ae=%b expected 1/0/1", fif.o_empty, fif.o_r_valid, fif.o_almost_empty); end
        fif.i_w_inc = 1; fif.i_w_data = 8'hA1; tick();
        fif.i_w_data = 8'hA2; tick();
        fif.i_w_inc = 0;
        n_vec++; if (fif.o_r_data !== 8'hA1) begin n_err++; $display("FAIL fwft_head1: got %h expected a1", fif.o_r_data); end
        fif.i_r_inc = 1; tick(); fif.i_r_inc = 0;
        n_vec++; if (fif.o_r_data !== 8'hA2 || fif.o_count !== 5'd1) begin n_err++; $display("FAIL fwft_head2: got d=%h c=%0d expected a2/1", fif.o_r_data, fif.o_count); end
        fif.i_r_inc = 1; tick(); fif.i_r_inc = 0;
        for (int i = 1; i <= 16; i++) begin
            fif.i_w_inc = 1; fif.i_w_data = 8'(8'hC0 + i);
            tick();
            n_vec++; if (fif.o_almost_full !== (i == 16) || fif.o_full !== (i == 16)) begin n_err++; $display("FAIL fwft_af[%0d]: got af=%b f=%b expected %b", i, fif.o_almost_full, fif.o_full, i == 16); end
        end
        fif.i_w_inc = 0;
        n_vec++; if (fif.o_r_data !== 8'hC1) begin n_err++; $display("FAIL fwft_fullhead: got %h expected c1", fif.o_r_data); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 16; i++) begin
            sif.i_w_inc = 1; sif.i_w_data = 8'(8'h70 + i);
            tick();
        end
        tick();
        sif.i_w_inc = 0;
        sif.i_r_inc = 1;
        for (int i = 0; i < 7; i++) tick();
        sif.i_r_inc = 0;
        n_vec++; if (sif.o_count !== 5'd9 || sif.o_overflow !== 1'b1) begin n_err++; $display("FAIL mid_pre: got c=%0d ovf=%b expected 9/1", sif.o_count, sif.o_overflow); end
        rst = 1; sif.i_clr_err = 1; sif.i_w_inc = 1; sif.i_w_data = 8'hCC;
        tick();
        rst = 0; sif.i_clr_err = 0; sif.i_w_inc = 0;
        n_vec++; if (sif.o_count !== 5'd0 || sif.o_empty !== 1'b1) begin n_err++; $display("FAIL mid_count: got c=%0d e=%b expected 0/1", sif.o_count, sif.o_empty); end
        n_vec++; if (sif.o_overflow !== 1'b0 || sif.o_r_valid !== 1'b0 || sif.o_r_data !== 8'h00) begin n_err++; $display("FAIL mid_flags: got ovf=%b v=%b d=%h expected 0/0/00", sif.o_overflow, sif.o_r_valid, sif.o_r_data); end
        n_vec++; if (fif.o_count !== 5'd0) begin n_err++; $display("FAIL mid_fwft_count: got %0d expected 0", fif.o_count); end
        tick();
        n_vec++; if (sif.o_count !== 5'd0 || sif.o_free_count !== 5'd16) begin n_err++; $display("FAIL mid_nowrite: got c=%0d free=%0d expected 0/16", sif.o_count, sif.o_free_count); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 0;
        idle_inputs();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_back_to_back();
        test_fwft();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
